// File: rtl/dividend_reconstructor_if.sv
// Start/Ack/Done handshake bundle with operand and result lines for dividend_reconstructor.
// The master side is the controller and the slave side is the reconstructor.
interface dividend_reconstructor_if;
  logic [7:0]  Qin;
  logic [7:0]  Yin;
  logic [7:0]  Rin;
  logic        Start;
  logic        Ack;
  logic        CEN;
  logic        Done;
  logic [15:0] Dividend;
  logic        RemOK;
  logic        Qi;
  logic        Qc;
  logic        Qd;

  modport master (
    output Qin, Yin, Rin, Start, Ack, CEN,
    input  Done, Dividend, RemOK, Qi, Qc, Qd
  );

  modport slave (
    input  Qin, Yin, Rin, Start, Ack, CEN,
    output Done, Dividend, RemOK, Qi, Qc, Qd
  );
endinterface

// File: rtl/dividend_reconstructor.sv
// Rebuilds a dividend as Q*Y + R with a shift-and-add multiplier.
// It also captures whether R < Y, so the remainder can be validated beside the divider.
module dividend_reconstructor (
  input  logic                    Clk,
  input  logic                    Reset_n,
  dividend_reconstructor_if.slave bus
);

  localparam int unsigned OP_W  = 8;
  localparam int unsigned RES_W = 16;

  typedef enum logic [2:0] {
    INITIAL = 3'b001,
    COMPUTE = 3'b010,
    DONE_S  = 3'b100
  } state_t;

  state_t            state, state_n;
  logic [OP_W-1:0]   qr, qr_n;
  logic [RES_W-1:0]  m, m_n;
  logic [RES_W-1:0]  acc, acc_n;
  logic              rem_ok, rem_ok_n;

  // State and datapath registers
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state  <= INITIAL;
      qr     <= '0;
      m      <= '0;
      acc    <= '0;
      rem_ok <= 1'b0;
    end else begin
      state  <= state_n;
      qr     <= qr_n;
      m      <= m_n;
      acc    <= acc_n;
      rem_ok <= rem_ok_n;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_n  = state;
    qr_n     = qr;
    m_n      = m;
    acc_n    = acc;
    rem_ok_n = rem_ok;
    unique case (state)
      INITIAL: begin
        // Operands track the inputs every cycle, so the Start edge latches them.
        qr_n     = bus.Qin;
        m_n      = RES_W'(bus.Yin);
        acc_n    = RES_W'(bus.Rin);
        rem_ok_n = (bus.Rin < bus.Yin);
        if (bus.Start) state_n = COMPUTE;
      end
      COMPUTE: begin
        if (bus.CEN) begin
          if (qr == '0) begin
            state_n = DONE_S;
          end else begin
            if (qr[0]) acc_n = RES_W'(acc + m);
            qr_n = qr >> 1;
            m_n  = m << 1;
          end
        end
      end
      DONE_S: begin
        if (bus.Ack) state_n = INITIAL;
      end
      default: state_n = INITIAL;
    endcase
  end

  assign bus.Qi       = state[0];
  assign bus.Qc       = state[1];
  assign bus.Qd       = state[2];
  assign bus.Done     = state[2];
  assign bus.Dividend = acc;
  assign bus.RemOK    = rem_ok;

endmodule

// File: tb/tb_dividend_reconstructor.sv
// Randomized self-checking bench for dividend_reconstructor.
// The expected results come from plain arithmetic on Q, Y and R.
module tb_dividend_reconstructor;

  logic Clk = 1'b0;
  logic Reset_n = 1'b1;

  dividend_reconstructor_if bus ();

  dividend_reconstructor dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus.slave)
  );

  always #5 Clk = ~Clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // The number of COMPUTE cycles that need CEN=1 is one more than the bit length of q.
  function automatic int bit_length(input logic [7:0] q);
    int k = 0;
    for (int b = 0; b < 8; b++) if (q[b]) k = b + 1;
    return k;
  endfunction

  // period 0 gives random CEN; period p>0 gives CEN high on every p-th COMPUTE cycle.
  task automatic run_op(input logic [7:0] q, input logic [7:0] y, input logic [7:0] r,
                        input int period, input bit ack_high);
    int          exp_div, k, cycles, ones, hold;
    bit          rem_exp, cen;
    logic [15:0] prev;
    exp_div = int'(q) * int'(y) + int'(r);
    rem_exp = (r < y);
    k       = bit_length(q);

    @(negedge Clk);
    bus.Qin = q; bus.Yin = y; bus.Rin = r;
    bus.Start = 1'b1; bus.Ack = ack_high; bus.CEN = 1'b0;
    @(posedge Clk); @(negedge Clk);
    bus.Start = 1'b0;
    // Operand changes after the Start edge must not leak into the run.
    bus.Qin = 8'($urandom); bus.Yin = 8'($urandom); bus.Rin = 8'($urandom);
    check("enter_compute", 32'(bus.Qc), 32'd1);

    cycles = 0;
    ones   = 0;
    while (bus.Qc === 1'b1 && cycles < 400) begin
      cen = (period == 0) ? ($urandom_range(0, 2) != 0) : ((cycles % period) == period - 1);
      bus.CEN = cen;
      prev = bus.Dividend;
      @(posedge Clk); @(negedge Clk);
      cycles++;
      if (cen) ones++;
      else if (period > 1) check("cen_hold", 32'(bus.Dividend), 32'(prev));
    end
    check("cen_cycles", 32'(ones), 32'(k + 1));
    if (period > 0) check("compute_len", 32'(cycles), 32'((k + 1) * period));
    check("done", 32'(bus.Done), 32'd1);
    check("qd", 32'(bus.Qd), 32'd1);
    check("dividend", 32'(bus.Dividend), 32'(exp_div));
    check("remok", 32'(bus.RemOK), 32'(rem_exp));

    bus.CEN = 1'($urandom_range(0, 1));
    if (ack_high) begin
      @(posedge Clk); @(negedge Clk);
      check("done_one_cycle", 32'(bus.Done), 32'd0);
      check("back_initial", 32'(bus.Qi), 32'd1);
    end else begin
      hold = $urandom_range(1, 3);
      repeat (hold) begin
        bus.Start = 1'($urandom_range(0, 1));
        @(posedge Clk); @(negedge Clk);
        check("done_hold", 32'(bus.Done), 32'd1);
        check("dividend_hold", 32'(bus.Dividend), 32'(exp_div));
      end
      bus.Start = 1'b0;
      bus.Ack   = 1'b1;
      @(posedge Clk); @(negedge Clk);
      check("ack_done", 32'(bus.Done), 32'd0);
      check("ack_initial", 32'(bus.Qi), 32'd1);
      bus.Ack = 1'b0;
    end
  endtask

  initial begin
    bus.Qin = '0; bus.Yin = '0; bus.Rin = '0;
    bus.Start = 1'b0; bus.Ack = 1'b0; bus.CEN = 1'b0;

    // Reset is applied before the first clock edge, so it acts without a clock.
    #1 Reset_n = 1'b0;
    #1;
    check("rst_done", 32'(bus.Done), 32'd0);
    check("rst_dividend", 32'(bus.Dividend), 32'd0);
    check("rst_remok", 32'(bus.RemOK), 32'd0);
    check("rst_state", 32'({bus.Qd, bus.Qc, bus.Qi}), 32'b001);
    @(negedge Clk);
    @(negedge Clk);
    Reset_n = 1'b1;

    run_op(8'd12, 8'd10, 8'd7, 1, 1'b0);
    run_op(8'd0, 8'd200, 8'd5, 1, 1'b0);
    run_op(8'd3, 8'd0, 8'd9, 1, 1'b0);
    run_op(8'd255, 8'd255, 8'd254, 1, 1'b0);
    run_op(8'd1, 8'd40, 8'd40, 1, 1'b0);
    run_op(8'd12, 8'd10, 8'd7, 3, 1'b0);
    run_op(8'd12, 8'd10, 8'd7, 1, 1'b1);
    run_op(8'd255, 8'd3, 8'd2, 1, 1'b1);

    // Reset in the third COMPUTE cycle, while the accumulator is still non-zero.
    @(negedge Clk);
    bus.Qin = 8'd12; bus.Yin = 8'd10; bus.Rin = 8'd7;
    bus.Start = 1'b1; bus.Ack = 1'b0; bus.CEN = 1'b1;
    @(posedge Clk); @(negedge Clk);
    bus.Start = 1'b0;
    @(posedge Clk); @(negedge Clk);
    @(posedge Clk); @(negedge Clk);
    check("pre_reset_dividend", 32'(bus.Dividend), 32'd7);
    Reset_n = 1'b0;
    #1;
    check("midrst_state", 32'({bus.Qd, bus.Qc, bus.Qi}), 32'b001);
    check("midrst_dividend", 32'(bus.Dividend), 32'd0);
    check("midrst_done", 32'(bus.Done), 32'd0);
    #2 Reset_n = 1'b1;
    run_op(8'd12, 8'd10, 8'd7, 1, 1'b0);

    for (int i = 0; i < 40; i++) begin
      run_op(8'($urandom), 8'($urandom), 8'($urandom),
             $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
